// File: rtl/div_seq_ctrl_if.sv
// Operand, divider and HI/LO bundle between the datapath control unit and div_seq_ctrl.
interface div_seq_ctrl_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [63:0] div_result;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wr_data;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport slave (
    input  start, dividend, divisor, div_result, hi_wr, lo_wr, wr_data,
    output div_a, div_b, hi, lo, busy, done, div_zero
  );

  modport master (
    output start, dividend, divisor, div_result, hi_wr, lo_wr, wr_data,
    input  div_a, div_b, hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Multicycle sequencer around a combinational divider: holds operands SETTLE_CYCLES clocks, then captures HI/LO.
// Optional zero-divisor trap (sticky div_zero, immediate done) is enabled by defining DIV_ZERO_TRAP_EN.
module div_seq_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic          clk,
  input logic          reset_n,
  div_seq_ctrl_if.slave bus
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef DIV_ZERO_TRAP_EN
  logic        div_zero_q, div_zero_d;
  logic        zero_divisor;

  assign zero_divisor = (bus.divisor == 32'd0);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      div_a_q    <= 32'd0;
      div_b_q    <= 32'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      div_zero_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef DIV_ZERO_TRAP_EN
      div_zero_q <= div_zero_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
`ifdef DIV_ZERO_TRAP_EN
          state_d = zero_divisor ? ST_IDLE : ST_WAIT;
`else
          state_d = ST_WAIT;
`endif
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
    div_zero_d = div_zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Move-to writes land now; a divide started this edge overwrites them at completion.
        if (bus.hi_wr) hi_d = bus.wr_data;
        if (bus.lo_wr) lo_d = bus.wr_data;
        if (bus.start) begin
          div_a_d = bus.dividend;
          div_b_d = bus.divisor;
`ifdef DIV_ZERO_TRAP_EN
          if (zero_divisor) begin
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            cnt_d      = CNT_INIT;
            busy_d     = 1'b1;
            div_zero_d = 1'b0;
          end
`else
          cnt_d  = CNT_INIT;
          busy_d = 1'b1;
`endif
        end
      end
      ST_WAIT: begin
        // Operands are frozen here; move-to writes and new starts are dropped.
        if (cnt_q == 4'd0) begin
          hi_d   = bus.div_result[63:32];
          lo_d   = bus.div_result[31:0];
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        busy_d = 1'b0;
      end
    endcase
  end

  assign bus.div_a    = div_a_q;
  assign bus.div_b    = div_b_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
`ifdef DIV_ZERO_TRAP_EN
  assign bus.div_zero = div_zero_q;
`else
  assign bus.div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl: directed divides push expected HI/LO and done cycle; a monitor checks each done.
module tb_div_seq_ctrl;
  localparam int S = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          cyc;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];

  div_seq_ctrl_if dif();

  div_seq_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dif.slave)
  );

  // Behavioural stand-in for the external combinational restoring divider.
  assign dif.div_result = (dif.div_b == 32'd0) ? {dif.div_a, 32'hFFFF_FFFF}
                                               : {dif.div_a % dif.div_b, dif.div_a / dif.div_b};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && dif.done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("hi", {32'd0, dif.hi}, {32'd0, e.hi});
        chk("lo", {32'd0, dif.lo}, {32'd0, e.lo});
        chk("div_zero_at_done", {63'd0, dif.div_zero}, {63'd0, e.dz});
      end
    end
  end

  // Caller positions at a negedge; returns #1 after the accepting edge.
  task automatic go(input logic [31:0] a, input logic [31:0] b, input bit push,
                    input logic [31:0] eh, input logic [31:0] el, input logic edz, input int lat);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    if (push) sb_q.push_back('{cyc + lat, eh, el, edz});
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dif.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("wait_done_timeout", 64'd0, 64'd1);
  endtask

  task automatic idle_gap();
    repeat (S + 3) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    dif.start    = 1'b0;
    dif.dividend = 32'd0;
    dif.divisor  = 32'd0;
    dif.hi_wr    = 1'b0;
    dif.lo_wr    = 1'b0;
    dif.wr_data  = 32'd0;

    #3 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, dif.busy}, 64'd0);
    chk("rst_done", {63'd0, dif.done}, 64'd0);
    chk("rst_hi", {32'd0, dif.hi}, 64'd0);
    chk("rst_lo", {32'd0, dif.lo}, 64'd0);
    chk("rst_div_a", {32'd0, dif.div_a}, 64'd0);
    chk("rst_div_zero", {63'd0, dif.div_zero}, 64'd0);
    reset_n = 1'b1;

    // 100/7: busy for S cycles, then done with lo=14 hi=2
    @(negedge clk);
    go(32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, S);
    chk("t1_div_a", {32'd0, dif.div_a}, 64'd100);
    chk("t1_div_b", {32'd0, dif.div_b}, 64'd7);
    for (int i = 1; i < S; i++) begin
      @(posedge clk); #1;
      chk("t1_busy_hold", {63'd0, dif.busy}, 64'd1);
    end
    @(posedge clk); #1;
    chk("t1_busy_end", {63'd0, dif.busy}, 64'd0);
    @(posedge clk); #1;
    chk("t1_done_pulse_width", {63'd0, dif.done}, 64'd0);
    idle_gap();

    // 1000/10 with an ignored 5/5 start two cycles in
    go(32'd1000, 32'd10, 1'b1, 32'd0, 32'd100, 1'b0, S);
    @(negedge clk);
    @(negedge clk);
    go(32'd5, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    chk("t2_div_a_stable", {32'd0, dif.div_a}, 64'd1000);
    chk("t2_div_b_stable", {32'd0, dif.div_b}, 64'd10);
    idle_gap();

    // 9/4 then 20/3 started in the done cycle
    go(32'd9, 32'd4, 1'b1, 32'd1, 32'd2, 1'b0, S);
    wait_done();
    go(32'd20, 32'd3, 1'b1, 32'd2, 32'd6, 1'b0, S);
    chk("t3_busy_back_to_back", {63'd0, dif.busy}, 64'd1);
    idle_gap();

    // Move-to writes in IDLE, then dropped during WAIT
    dif.hi_wr = 1'b1; dif.wr_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dif.hi_wr = 1'b0; dif.lo_wr = 1'b1; dif.wr_data = 32'h0000_1234;
    @(posedge clk); #1;
    dif.lo_wr = 1'b0;
    chk("t4_hi_write", {32'd0, dif.hi}, 64'hDEAD_BEEF);
    chk("t4_lo_write", {32'd0, dif.lo}, 64'h0000_1234);
    @(negedge clk);
    go(32'd7, 32'd2, 1'b1, 32'd1, 32'd3, 1'b0, S);
    dif.hi_wr = 1'b1; dif.lo_wr = 1'b1; dif.wr_data = 32'h5555_5555;
    @(negedge clk);
    chk("t4_hi_wait_hold", {32'd0, dif.hi}, 64'hDEAD_BEEF);
    chk("t4_lo_wait_hold", {32'd0, dif.lo}, 64'h0000_1234);
    wait_done();
    dif.hi_wr = 1'b0; dif.lo_wr = 1'b0;
    idle_gap();

    // Reset in cycle 2 of WAIT aborts 50/6
    go(32'd50, 32'd6, 1'b0, 32'd0, 32'd0, 1'b0, 0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("t5_busy", {63'd0, dif.busy}, 64'd0);
    chk("t5_done", {63'd0, dif.done}, 64'd0);
    chk("t5_hi", {32'd0, dif.hi}, 64'd0);
    chk("t5_lo", {32'd0, dif.lo}, 64'd0);
    chk("t5_div_a", {32'd0, dif.div_a}, 64'd0);
    chk("t5_div_b", {32'd0, dif.div_b}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    go(32'd12, 32'd5, 1'b1, 32'd2, 32'd2, 1'b0, S);
    chk("t5_restart_busy", {63'd0, dif.busy}, 64'd1);
    idle_gap();

`ifdef DIV_ZERO_TRAP_EN
    dif.hi_wr = 1'b1; dif.wr_data = 32'd3;
    @(posedge clk); #1;
    dif.hi_wr = 1'b0; dif.lo_wr = 1'b1; dif.wr_data = 32'd4;
    @(posedge clk); #1;
    dif.lo_wr = 1'b0;
    @(negedge clk);
    go(32'd77, 32'd0, 1'b1, 32'd3, 32'd4, 1'b1, 1);
    chk("t6_div_zero_set", {63'd0, dif.div_zero}, 64'd1);
    chk("t6_no_busy", {63'd0, dif.busy}, 64'd0);
    @(negedge clk);
    go(32'd8, 32'd2, 1'b1, 32'd0, 32'd4, 1'b0, S);
    chk("t6_div_zero_clear", {63'd0, dif.div_zero}, 64'd0);
`else
    go(32'd9, 32'd0, 1'b1, 32'd9, 32'hFFFF_FFFF, 1'b0, S);
    chk("t6_div_zero_tied", {63'd0, dif.div_zero}, 64'd0);
    chk("t6_zero_busy", {63'd0, dif.busy}, 64'd1);
`endif
    idle_gap();

    chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
